// File: rtl/floppy_pkg.sv
// ---------------------------------------------------------------------------
// floppy_pkg : shared constants, state encoding and LBA helper for the
//              floppy track cache.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package floppy_pkg;

  localparam int SECTOR_BYTES      = 512;
  localparam int SECTORS_PER_TRACK = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_SEL  = 3'd1,
    WB_REQ  = 3'd2,
    WB_XFER = 3'd3,
    RD_REQ  = 3'd4,
    RD_XFER = 3'd5
  } fct_state_t;

  function automatic logic [31:0] track_lba(input logic [7:0] track, input logic [3:0] sec);
    return 32'(track) * 32'(SECTORS_PER_TRACK) + 32'(sec);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_track.sv
// ---------------------------------------------------------------------------
// dpram_track : true dual-port byte RAM, both ports on one clock, registered
//               reads.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpram_track #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          we_a,
  output logic [DW-1:0] dout_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  input  logic          we_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [2**AW];

  // Single process so the array has one driver; on an address collision the
  // controller-side write lands last and wins.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

`default_nettype wire

// File: rtl/floppy_track_cache.sv
// ---------------------------------------------------------------------------
// floppy_track_cache : one-track buffer between the Disk II controller and the
//                      SD block interface, with per-sector write-back.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module floppy_track_cache
  import floppy_pkg::*;
#(
  parameter int SECTORS = SECTORS_PER_TRACK,
  parameter int TRACK_W = 6,
  parameter int BUF_AW  = 14
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic [BUF_AW-1:0]  fd_track_addr,
  output logic [7:0]         fd_data_in,
  input  logic [7:0]         fd_data_do,
  input  logic               fd_write_disk,
  output logic               cpu_wait,
  input  logic               img_mounted,
  input  logic               img_readonly,
  input  logic [63:0]        img_size,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  output logic [7:0]         sd_buff_din,
  input  logic               sd_buff_wr
);

  fct_state_t         state, state_n;
  logic [SECTORS-1:0] dirty, dirty_n;
  logic               valid, valid_n;
  logic [TRACK_W-1:0] cur_track, cur_track_n;
  logic [3:0]         sec, sec_n;
  logic               ack_q;
  logic [3:0]         first_dirty;
  logic [3:0]         fd_sec;
  logic               ack_rise, ack_fall, has_disk, trigger, dirty_set;
  logic [BUF_AW-1:0]  addr_a;

  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;
  assign has_disk  = |img_size;
  assign trigger   = (track != cur_track) | (~valid & has_disk);
  assign fd_sec    = fd_track_addr[12:9];
  assign dirty_set = fd_write_disk & valid & ~img_readonly & (fd_sec < 4'(SECTORS));
  assign sd_lba    = track_lba(8'(cur_track), sec);
  assign addr_a    = BUF_AW'({sec, sd_buff_addr});

  dpram_track #(.AW(BUF_AW), .DW(8)) u_buf (
    .clk    (clk_sys),
    .addr_a (addr_a),
    .din_a  (sd_buff_dout),
    .we_a   (sd_buff_wr & sd_ack & (state == RD_XFER)),
    .dout_a (sd_buff_din),
    .addr_b (fd_track_addr),
    .din_b  (fd_data_do),
    .we_b   (fd_write_disk),
    .dout_b (fd_data_in)
  );

  always_comb begin
    first_dirty = '0;
    for (int i = SECTORS - 1; i >= 0; i--)
      if (dirty[i]) first_dirty = 4'(i);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      dirty     <= '0;
      valid     <= 1'b0;
      cur_track <= '0;
      sec       <= '0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_n;
      dirty     <= dirty_n;
      valid     <= valid_n;
      cur_track <= cur_track_n;
      sec       <= sec_n;
      ack_q     <= sd_ack;
    end
  end

  always_comb begin
    state_n     = state;
    dirty_n     = dirty;
    valid_n     = valid;
    cur_track_n = cur_track;
    sec_n       = sec;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    cpu_wait    = (state != IDLE);

    case (state)
      IDLE: begin
        // A mount pulse only clears state; the reload starts next cycle.
        if (!reset && !img_mounted && trigger) begin
          if (!has_disk) begin
            valid_n     = 1'b0;
            cur_track_n = track;
          end else begin
            cpu_wait = 1'b1;
            if (valid && |dirty) begin
              state_n = WB_SEL;
            end else begin
              cur_track_n = track;
              sec_n       = '0;
              state_n     = RD_REQ;
            end
          end
        end
      end
      WB_SEL: begin
        if (|dirty) begin
          sec_n   = first_dirty;
          state_n = WB_REQ;
        end else begin
          cur_track_n = track;
          sec_n       = '0;
          state_n     = RD_REQ;
        end
      end
      WB_REQ: begin
        sd_wr = 1'b1;
        if (ack_rise) state_n = WB_XFER;
      end
      WB_XFER: begin
        if (ack_fall) begin
          dirty_n[sec] = 1'b0;
          state_n      = WB_SEL;
        end
      end
      RD_REQ: begin
        sd_rd = 1'b1;
        if (ack_rise) state_n = RD_XFER;
      end
      RD_XFER: begin
        if (ack_fall) begin
          if (sec == 4'(SECTORS - 1)) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            sec_n   = sec + 4'd1;
            state_n = RD_REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A late controller write outranks the write-back clear of the same sector.
    if (dirty_set) dirty_n[fd_sec] = 1'b1;
    if (img_mounted) begin
      dirty_n = '0;
      valid_n = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_floppy_track_cache.sv
// ---------------------------------------------------------------------------
// tb_floppy_track_cache : scoreboard bench with a behavioural SD host.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_floppy_track_cache;
  import floppy_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic [13:0] fd_track_addr;
  logic [7:0]  fd_data_in;
  logic [7:0]  fd_data_do;
  logic        fd_write_disk;
  logic        cpu_wait;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  always #5 clk_sys = ~clk_sys;

  floppy_track_cache dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .track         (track),
    .fd_track_addr (fd_track_addr),
    .fd_data_in    (fd_data_in),
    .fd_data_do    (fd_data_do),
    .fd_write_disk (fd_write_disk),
    .cpu_wait      (cpu_wait),
    .img_mounted   (img_mounted),
    .img_readonly  (img_readonly),
    .img_size      (img_size),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_din   (sd_buff_din),
    .sd_buff_wr    (sd_buff_wr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] lba;
    logic        chk;
    logic [3:0]  idx;
    logic [7:0]  val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] wbuf [16];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Image content the host serves; sector 3 byte 7 of the image carries 0xA5.
  function automatic logic [7:0] hp(input logic [31:0] lba, input int i);
    if (lba == 32'd3 && i == 7) return 8'hA5;
    return 8'(lba * 32'd31 + 32'(i));
  endfunction

  task automatic push_rd(input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '{wr: 1'b0, lba: 32'(first + k), chk: 1'b0, idx: 4'd0, val: 8'd0};
      sb.push_back(e);
    end
  endtask

  task automatic push_wr(input int lba, input int idx, input logic [7:0] val);
    exp_t e;
    e = '{wr: 1'b1, lba: 32'(lba), chk: 1'b1, idx: 4'(idx), val: val};
    sb.push_back(e);
  endtask

  task automatic fd_write(input logic [13:0] a, input logic [7:0] d);
    fd_track_addr = a;
    fd_data_do    = d;
    fd_write_disk = 1'b1;
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    ok = 1'b1;
    while (!sd_rd && !sd_wr) begin
      if (n >= 500) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk_sys);
      n++;
    end
  endtask

  // Acknowledge one request and move 16 bytes of it in either direction.
  task automatic serve(output logic was_wr, output logic [31:0] lba, output logic ok);
    was_wr = 1'b0;
    lba    = '0;
    wait_req(ok);
    if (!ok) return;
    was_wr = sd_wr;
    lba    = sd_lba;
    check("cpu_wait_busy", cpu_wait, 1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("req_dropped", {31'd0, sd_rd | sd_wr}, 0);
    for (int i = 0; i < 16; i++) begin
      sd_buff_addr = 9'(i);
      if (!was_wr) begin
        sd_buff_dout = hp(lba, i);
        sd_buff_wr   = 1'b1;
      end
      @(negedge clk_sys);
      if (was_wr) wbuf[i] = sd_buff_din;
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic run_seq();
    exp_t        e;
    logic        w;
    logic [31:0] l;
    logic        ok;
    while (sb.size() > 0) begin
      serve(w, l, ok);
      check("req_seen", {31'd0, ok}, 1);
      if (!ok) begin
        sb.delete();
        return;
      end
      e = sb.pop_front();
      check("req_kind", {31'd0, w}, {31'd0, e.wr});
      check("req_lba", l, e.lba);
      if (e.wr) begin
        check("wb_byte0", {24'd0, wbuf[0]}, {24'd0, hp(l, 0)});
        if (e.chk) check("wb_byte", {24'd0, wbuf[e.idx]}, {24'd0, e.val});
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cpu_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("idle_wait", {31'd0, cpu_wait}, 0);
    check("valid_set", {31'd0, dut.valid}, 1);
    check("no_req", {30'd0, sd_rd, sd_wr}, 0);
  endtask

  initial begin
    logic ok;
    reset         = 1'b1;
    track         = 6'd0;
    fd_track_addr = '0;
    fd_data_do    = '0;
    fd_write_disk = 1'b0;
    img_mounted   = 1'b0;
    img_readonly  = 1'b0;
    img_size      = '0;
    sd_ack        = 1'b0;
    sd_buff_addr  = '0;
    sd_buff_dout  = '0;
    sd_buff_wr    = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_cpu_wait", {31'd0, cpu_wait}, 0);
    check("rst_rdwr", {30'd0, sd_rd, sd_wr}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_valid", {31'd0, dut.valid}, 0);

    // Mount and load track 0.
    img_size    = 64'd143360;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    push_rd(0, 13);
    run_seq();
    wait_idle();

    fd_track_addr = 14'h0607;
    @(negedge clk_sys);
    check("rdback_a5", {24'd0, fd_data_in}, 32'h0000_00A5);
    fd_track_addr = 14'h0C05;
    @(negedge clk_sys);
    check("rdback_s6", {24'd0, fd_data_in}, {24'd0, hp(6, 5)});

    // Clean step 0 -> 5.
    track = 6'd5;
    #1;
    check("wait_same_cycle", {31'd0, cpu_wait}, 1);
    push_rd(65, 13);
    run_seq();
    wait_idle();

    // Dirty sectors 2 and 9, then step to 6.
    fd_write(14'h0405, 8'h3C);
    fd_write(14'h120B, 8'hC3);
    check("dirty_2_9", {19'd0, dut.dirty}, 32'h0000_0204);
    track = 6'd6;
    push_wr(67, 5, 8'h3C);
    push_wr(74, 11, 8'hC3);
    push_rd(78, 13);
    run_seq();
    wait_idle();
    check("dirty_clear", {19'd0, dut.dirty}, 0);

    // Write-protected image: nothing marked, nothing written back.
    img_readonly = 1'b1;
    fd_write(14'h0805, 8'h11);
    check("ro_dirty", {19'd0, dut.dirty}, 0);
    track = 6'd7;
    push_rd(91, 13);
    run_seq();
    wait_idle();
    img_readonly = 1'b0;

    // Out-of-range sector index is ignored; the last sector is tracked.
    fd_write(14'h1A05, 8'h55);
    check("oob_dirty", {19'd0, dut.dirty}, 0);
    fd_write(14'h1805, 8'h77);
    check("s12_dirty", {19'd0, dut.dirty}, 32'h0000_1000);

    // Step to 8 and reset while sector 6 is transferring.
    track = 6'd8;
    push_wr(103, 5, 8'h77);
    push_rd(104, 6);
    run_seq();
    wait_req(ok);
    check("req6_seen", {31'd0, ok}, 1);
    check("req6_lba", sd_lba, 32'd110);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("in_rd_xfer", 32'(dut.state), 32'(RD_XFER));
    reset  = 1'b1;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check("rst_mid_rd", {31'd0, sd_rd}, 0);
    check("rst_mid_wait", {31'd0, cpu_wait}, 0);
    check("rst_mid_valid", {31'd0, dut.valid}, 0);
    reset       = 1'b0;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    push_rd(104, 13);
    run_seq();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/floppy_track_cache.md
Name: floppy_track_cache

Overview:
- Single-track buffer and SD sector sequencer that sits between the Disk II floppy controller in apple2_top (track number, track byte address, read/write data) and the emu SD block interface (sd_lba[0]/sd_rd[0]/sd_wr[0]/sd_ack[0]).
- On a head-step to a new track, it writes back any dirty sectors of the current track, then loads the 13 sectors of the new track.
- It stalls the CPU for the whole operation.
- Dirty sectors are tracked individually, so only modified 512-byte sectors are written back.

Parameters:
- SECTORS, 13, sectors per track (512 bytes each).
- TRACK_W, 6, width of the track number.
- BUF_AW, 14, track buffer byte address width (capacity SECTORS*512 = 6656 bytes).

Ports:
- clk_sys  in  1  system clock (14 MHz domain).
- reset  in  1  synchronous, active-high.
- track  in  TRACK_W  current head track from the floppy controller.
- fd_track_addr  in  BUF_AW  byte offset within the track.
- fd_data_in  out  8  buffer read data; registered, 1-cycle latency.
- fd_data_do  in  8  write data from the controller.
- fd_write_disk  in  1  byte write strobe.
- cpu_wait  out  1  CPU stall request.
- img_mounted  in  1  mount pulse (one cycle).
- img_readonly  in  1  image is write-protected.
- img_size  in  64  image size; 0 means no disk.
- sd_lba  out  32  sector LBA.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- sd_ack  in  1  host is transferring the sector.
- sd_buff_addr  in  9  byte index within the sector.
- sd_buff_dout  in  8  host-to-buffer data.
- sd_buff_din  out  8  buffer-to-host data; 1-cycle latency from sd_buff_addr.
- sd_buff_wr  in  1  host byte write strobe.

Behaviour:
- Reset values:
  - state IDLE; sd_rd=0, sd_wr=0, cpu_wait=0, sd_lba=0.
  - dirty[SECTORS-1:0]=0, valid=0, cur_track=0, sec=0.
  - fd_data_in and sd_buff_din are undefined until the first read.
  - Reset mid-transfer aborts immediately; the buffer contents are not cleared.
- Buffer: true dual-port RAM.
  - Port A (SD side): address {sec, sd_buff_addr}. Write when sd_buff_wr & sd_ack & state==RD_XFER.
  - Port B (controller side): address fd_track_addr. Write on fd_write_disk.
- Dirty tracking: fd_write_disk & valid & ~img_readonly & fd_track_addr[12:9]<SECTORS sets dirty[fd_track_addr[12:9]]. An out-of-range sector index is ignored.
- Mount:
  - img_mounted clears dirty and valid. Un-flushed data from the old image is discarded.
  - When img_size != 0, the pulse also forces a load of track.
- Trigger in IDLE: (track != cur_track) or (~valid & img_size != 0).
  - If img_size == 0: set valid=0, cur_track=track, and stay IDLE.
  - If any dirty bit is set and valid: go to WB_SEL, keeping the old cur_track.
  - Otherwise: set cur_track=track and go to RD_REQ with sec=0.
- States:
  - IDLE: cpu_wait=0.
  - WB_SEL: sec = lowest set dirty index; go to WB_REQ. If no dirty bit remains, set cur_track=track, sec=0, go to RD_REQ.
  - WB_REQ: sd_lba = cur_track*SECTORS + sec; assert sd_wr; wait for sd_ack rise, then go to WB_XFER.
  - WB_XFER: sd_wr=0. On sd_ack fall, clear dirty[sec] and go to WB_SEL.
  - RD_REQ: sd_lba = cur_track*SECTORS + sec; assert sd_rd; wait for sd_ack rise, then go to RD_XFER.
  - RD_XFER: sd_rd=0. On sd_ack fall: if sec==SECTORS-1, set valid=1 and go to IDLE; else sec+1 and go to RD_REQ.
- Handshake rules:
  - sd_rd/sd_wr are held from the REQ entry cycle until the cycle after the sd_ack rising edge is sampled.
  - Edges are detected against a registered copy of sd_ack.
- cpu_wait: 1 in every state other than IDLE, asserted in the same cycle the trigger is taken.
- Track changes during a transfer are ignored. They are re-evaluated on return to IDLE, where a mismatch triggers a new sequence.
- LBA arithmetic: 32-bit, track zero-extended, multiply by the constant SECTORS.
- fd_write_disk during a non-IDLE state still writes the buffer and marks dirty. The CPU is stalled, so only a late controller write can occur; such a write is kept.

Decomposition:
- Package floppy_pkg:
  - SECTOR_BYTES=512, SECTORS_PER_TRACK=13.
  - State enum fct_state_t {IDLE, WB_SEL, WB_REQ, WB_XFER, RD_REQ, RD_XFER}.
  - Function track_lba(track, sec).
- Sub-module: dpram_track (generic two-clock-port BRAM, 8xBUF_AW, both ports on clk_sys); instantiated once.

Test Plan:
- Mount, load: img_size=143360, img_mounted pulse, track=0. Expect 13 read requests with sd_lba 0..12; cpu_wait high throughout; after the last ack fall, valid=1 and cpu_wait=0.
- Read-back: host writes 0xA5 at sector 3, byte 7 during the load. fd_track_addr=0x0607 gives fd_data_in=0xA5 one cycle later.
- Step, clean track: track 0->5 with no writes. Expect no sd_wr, and sd_rd with lba 65..77.
- Step, dirty track: write bytes at sector 2 and sector 9 on track 5, then step to 6.
  - Expect sd_wr at lba 67, then 74; sd_buff_din returns the written bytes.
  - Then sd_rd at lba 78..90; dirty==0 afterwards.
- Readonly: img_readonly=1, write at sector 4, step track. Expect no sd_wr.
- Reset mid-load: assert reset while in RD_XFER at sec=6. Expect sd_rd=0, cpu_wait=0, valid=0 the next cycle; a subsequent img_mounted pulse reloads from lba 13*track.
